// File: rtl/fifo_writer_helper_if.sv
// Byte-in / word-out handshake bundle for fifo_writer_helper.
// master: the side that drives the frame (request, bytes, FIFO full flag).
// slave : the packer itself.
interface fifo_writer_helper_if #(
  parameter int LEN_W = 6
);
  logic             Write_Request;
  logic [LEN_W-1:0] i_TX_BUFFER_LENGTH;
  logic [7:0]       i_byte;
  logic             i_byte_valid;
  logic             o_byte_ready;
  logic             i_FIFO_full;
  logic [31:0]      o_FIFO_din;
  logic             o_FIFO_wr_en;
  logic             o_busy;
  logic             o_done;
  logic [1:0]       Pack_Counter;

  modport master (
    output Write_Request, i_TX_BUFFER_LENGTH, i_byte, i_byte_valid, i_FIFO_full,
    input  o_byte_ready, o_FIFO_din, o_FIFO_wr_en, o_busy, o_done, Pack_Counter
  );

  modport slave (
    input  Write_Request, i_TX_BUFFER_LENGTH, i_byte, i_byte_valid, i_FIFO_full,
    output o_byte_ready, o_FIFO_din, o_FIFO_wr_en, o_busy, o_done, Pack_Counter
  );
endinterface

// File: rtl/fifo_writer_helper.sv
// fifo_writer_helper: packs a length-framed byte stream little-endian into
// 32-bit words (byte 0 in [7:0]) and writes each word into the TX/RCC FIFO.
// Optional build macro FIFO_WRITER_PAD_EN: unused lanes of a final partial
// word carry PAD_BYTE instead of 8'h00.

// One byte lane of the word register: reloaded with the fill value at the
// start of each word, written once when its byte arrives.
module fifo_writer_helper_lane (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] fill,
  input  logic [7:0] d,
  output logic [7:0] q
);
  // Lane storage; clear and load never coincide (different FSM states).
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)   q <= '0;
    else if (clr)  q <= fill;
    else if (load) q <= d;
  end
endmodule

module fifo_writer_helper #(
  parameter int         LEN_W    = 6,
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input logic                 CLK,
  input logic                 RESETn,
  fifo_writer_helper_if.slave bus
);
  localparam int NUM_LANES = 4;

`ifdef FIFO_WRITER_PAD_EN
  localparam logic [7:0] FILL = PAD_BYTE;
`else
  // Padding disabled: fill is forced to zero whatever PAD_BYTE says.
  localparam logic [7:0] FILL = PAD_BYTE & 8'h00;
`endif

  typedef enum logic [1:0] {W_IDLE, W_PACK, W_WRITE, W_DONE} wstate_t;

  wstate_t                        st, nxt;
  logic [LEN_W-1:0]               len_q;
  logic [LEN_W-1:0]               byte_cnt;
  logic [LEN_W-1:0]               byte_cnt_inc;
  logic [1:0]                     pack_cnt;
  logic [NUM_LANES-1:0][7:0]      lane_q;
  logic [NUM_LANES-1:0]           lane_ld;
  logic                           start;
  logic                           accept;
  logic                           wr_en;
  logic                           ready;
  logic                           word_clr;

  // byte_cnt < len_q whenever a byte is accepted, so this never overflows.
  assign byte_cnt_inc = byte_cnt + LEN_W'(1);

  // State register.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) st <= W_IDLE;
    else         st <= nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    nxt    = st;
    ready  = 1'b0;
    wr_en  = 1'b0;
    accept = 1'b0;
    start  = 1'b0;
    case (st)
      W_IDLE: begin
        if (bus.Write_Request) begin
          start = 1'b1;
          nxt   = (bus.i_TX_BUFFER_LENGTH == '0) ? W_DONE : W_PACK;
        end
      end
      W_PACK: begin
        ready = 1'b1;
        if (bus.i_byte_valid) begin
          accept = 1'b1;
          // Word is complete on lane 3 or on the frame's last byte.
          if (pack_cnt == 2'd3 || byte_cnt_inc == len_q) nxt = W_WRITE;
        end
      end
      W_WRITE: begin
        wr_en = ~bus.i_FIFO_full;
        if (!bus.i_FIFO_full) nxt = (byte_cnt < len_q) ? W_PACK : W_DONE;
      end
      W_DONE:  nxt = W_IDLE;
      default: nxt = W_IDLE;
    endcase
  end

  // A fresh word starts on frame accept and after every completed write.
  assign word_clr = start | wr_en;

  // Frame length and byte/lane counters.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      len_q    <= '0;
      byte_cnt <= '0;
      pack_cnt <= '0;
    end else if (start) begin
      len_q    <= bus.i_TX_BUFFER_LENGTH;
      byte_cnt <= '0;
      pack_cnt <= '0;
    end else if (accept) begin
      byte_cnt <= byte_cnt_inc;
      pack_cnt <= pack_cnt + 2'd1;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_ld[i] = accept && (pack_cnt == 2'(i));
    fifo_writer_helper_lane u_lane (
      .CLK    (CLK),
      .RESETn (RESETn),
      .clr    (word_clr),
      .load   (lane_ld[i]),
      .fill   (FILL),
      .d      (bus.i_byte),
      .q      (lane_q[i])
    );
  end

  assign bus.o_FIFO_din   = lane_q;
  assign bus.o_FIFO_wr_en = wr_en;
  assign bus.o_byte_ready = ready;
  assign bus.o_busy       = (st != W_IDLE);
  assign bus.o_done       = (st == W_DONE);
  assign bus.Pack_Counter = pack_cnt;
endmodule
